// File: rtl/alif_sched_pkg.sv
// Shared definitions for the ALIF timestep scheduler.
//   - datapath opcodes driven on dp_op
//   - scheduler FSM state encoding
//   - configuration register addresses and reset values
//   - default neuron count
package alif_sched_pkg;

  localparam int N_NEURONS_DEF = 2;

  // Shared datapath opcodes
  localparam logic [1:0] OP_UPDATE = 2'b00;  // integrate + leak + threshold
  localparam logic [1:0] OP_CLAMP  = 2'b01;  // hold membrane at rest

  // Configuration register map
  localparam logic [1:0] CFG_PRESCALE = 2'd0;
  localparam logic [1:0] CFG_REFRAC0  = 2'd1;  // neuron i lives at CFG_REFRAC0 + i
  localparam logic [1:0] CFG_REFRAC1  = 2'd2;

  // Configuration reset values
  localparam logic [7:0] PRESCALE_RST = 8'd9;
  localparam int         REFRAC_RST   = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alif_prescaler.sv
// Timestep prescaler.
// Counts 0..prescale while en is high and emits a registered one-cycle
// tick on the cycle after the count reaches prescale, wrapping to 0.
// A prescale value below the current count makes the counter run on
// through 255 and wrap naturally before matching again.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   en         count enable (holds count when low, no tick)
//   prescale   terminal count
//   tick       one-cycle timestep pulse
module alif_prescaler (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] prescale,
  output logic       tick
);

  logic [7:0] count_reg;
  logic       tick_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= 8'd0;
      tick_reg  <= 1'b0;
    end else begin
      tick_reg <= 1'b0;
      if (en) begin
        if (count_reg == prescale) begin
          count_reg <= 8'd0;
          tick_reg  <= 1'b1;
        end else begin
          count_reg <= count_reg + 8'd1;
        end
      end
    end
  end

  assign tick = tick_reg;

endmodule

// File: rtl/alif_step_sched.sv
// ALIF timestep scheduler.
// On every prescaler tick, walks the neurons in order and issues one
// request per neuron to a shared membrane-update datapath: CLAMP while the
// neuron is refractory, UPDATE otherwise. Spikes reported with UPDATE
// transfers are collected and presented as a one-cycle spike_out pulse
// once all neurons have been serviced.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   en              prescaler run enable
//   cfg_we/addr/data configuration write (prescale, refractory periods)
//   dp_req/sel/op   request, neuron index and opcode to the datapath
//   dp_ack/spike    datapath accept and threshold-crossing result
//   step_tick       timestep pulse
//   spike_out       per-neuron spike pulse for the completed step
//   refrac_active   per-neuron refractory counter nonzero
//   busy            step sequence in progress
//   overrun         sticky: a tick arrived while busy
module alif_step_sched
  import alif_sched_pkg::*;
#(
  parameter int N_NEURONS = N_NEURONS_DEF,
  parameter int REFRAC_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 cfg_we,
  input  logic [1:0]           cfg_addr,
  input  logic [7:0]           cfg_data,
  output logic                 dp_req,
  output logic                 dp_sel,
  output logic [1:0]           dp_op,
  input  logic                 dp_ack,
  input  logic                 dp_spike,
  output logic                 step_tick,
  output logic [N_NEURONS-1:0] spike_out,
  output logic [N_NEURONS-1:0] refrac_active,
  output logic                 busy,
  output logic                 overrun
);

  localparam logic IDX_LAST = 1'(N_NEURONS - 1);

  // Configuration registers
  logic [7:0]                         prescale_reg;
  logic [N_NEURONS-1:0][REFRAC_W-1:0] refrac_period_reg;

  // Scheduler state
  state_t                             state_reg, state_next;
  logic                               idx_reg, idx_next;
  logic [N_NEURONS-1:0]               acc_reg, acc_next;
  logic [N_NEURONS-1:0][REFRAC_W-1:0] refrac_cnt_reg, refrac_cnt_next;
  logic                               overrun_reg, overrun_next;

  logic tick;
  logic clamp;

  alif_prescaler u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .prescale (prescale_reg),
    .tick     (tick)
  );

  // Config writes are allowed at any time. A new refractory period is only
  // sampled when a spike loads the counter, so in-flight refractory windows
  // finish with the value they started with.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescale_reg <= PRESCALE_RST;
      for (int i = 0; i < N_NEURONS; i++) begin
        refrac_period_reg[i] <= REFRAC_W'(REFRAC_RST);
      end
    end else if (cfg_we) begin
      if (cfg_addr == CFG_PRESCALE) begin
        prescale_reg <= cfg_data;
      end
      for (int i = 0; i < N_NEURONS; i++) begin
        if (32'(cfg_addr) == 32'(CFG_REFRAC0) + 32'(i)) begin
          refrac_period_reg[i] <= cfg_data[REFRAC_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      idx_reg        <= 1'b0;
      acc_reg        <= '0;
      refrac_cnt_reg <= '0;
      overrun_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      acc_reg        <= acc_next;
      refrac_cnt_reg <= refrac_cnt_next;
      overrun_reg    <= overrun_next;
    end
  end

  assign clamp = (refrac_cnt_reg[idx_reg] != '0);

  always_comb begin
    state_next      = state_reg;
    idx_next        = idx_reg;
    acc_next        = acc_reg;
    refrac_cnt_next = refrac_cnt_reg;
    // Ticks during a step are dropped, never queued; remember that it happened.
    overrun_next    = overrun_reg | (tick & (state_reg != ST_IDLE));

    case (state_reg)
      ST_IDLE: begin
        if (tick) begin
          state_next = ST_REQ;
          idx_next   = 1'b0;
        end
      end
      ST_REQ: begin
        if (dp_ack) begin
          if (clamp) begin
            refrac_cnt_next[idx_reg] = refrac_cnt_reg[idx_reg] - 1'b1;
          end else if (dp_spike) begin
            acc_next[idx_reg]        = 1'b1;
            refrac_cnt_next[idx_reg] = refrac_period_reg[idx_reg];
          end
          if (idx_reg == IDX_LAST) begin
            state_next = ST_DONE;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      ST_DONE: begin
        acc_next   = '0;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign dp_req    = (state_reg == ST_REQ);
  assign dp_sel    = idx_reg;
  assign dp_op     = clamp ? OP_CLAMP : OP_UPDATE;
  assign step_tick = tick;
  assign spike_out = (state_reg == ST_DONE) ? acc_reg : '0;
  assign busy      = (state_reg != ST_IDLE);
  assign overrun   = overrun_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N_NEURONS; gi++) begin : g_refrac_flag
      assign refrac_active[gi] = |refrac_cnt_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_alif_step_sched.sv
module tb_alif_step_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_addr = 2'd0;
  logic [7:0] cfg_data = 8'd0;
  logic       dp_ack = 1'b1;
  logic       dp_spike = 1'b0;
  logic       dp_req;
  logic       dp_sel;
  logic [1:0] dp_op;
  logic       step_tick;
  logic [1:0] spike_out;
  logic [1:0] refrac_active;
  logic       busy;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_tick = 0;

  alif_step_sched dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .cfg_we        (cfg_we),
    .cfg_addr      (cfg_addr),
    .cfg_data      (cfg_data),
    .dp_req        (dp_req),
    .dp_sel        (dp_sel),
    .dp_op         (dp_op),
    .dp_ack        (dp_ack),
    .dp_spike      (dp_spike),
    .step_tick     (step_tick),
    .spike_out     (spike_out),
    .refrac_active (refrac_active),
    .busy          (busy),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] spk;   // dp_spike per neuron
    logic [1:0] op0;   // expected opcode for neuron 0
    logic [1:0] op1;   // expected opcode for neuron 1
    logic [1:0] sout;  // expected spike_out pulse
    logic [1:0] ract;  // expected refrac_active after the step
  } step_vec_t;

  step_vec_t tbl [8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(input int budget, output int tc);
    tc = -1;
    for (int k = 0; k < budget; k++) begin
      next_cyc();
      if (step_tick) begin
        tc = cyc;
        break;
      end
    end
    if (tc < 0) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: got none expected tick within %0d cycles", budget);
    end
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    next_cyc();
    cfg_we = 1'b0;
  endtask

  // One full step with dp_ack high: tick at T, requests at T+1/T+2,
  // spike_out at T+3, idle again at T+4.
  task automatic run_step(input step_vec_t v, input int n);
    int t;
    wait_tick(300, t);
    if (t < 0) return;
    chk($sformatf("step%0d_tick_gap", n), t - last_tick, 10);
    last_tick = t;
    next_cyc();
    chk($sformatf("step%0d_req0", n), dp_req, 1);
    chk($sformatf("step%0d_sel0", n), dp_sel, 0);
    chk($sformatf("step%0d_op0", n), dp_op, v.op0);
    dp_spike = v.spk[0];
    next_cyc();
    chk($sformatf("step%0d_req1", n), dp_req, 1);
    chk($sformatf("step%0d_sel1", n), dp_sel, 1);
    chk($sformatf("step%0d_op1", n), dp_op, v.op1);
    dp_spike = v.spk[1];
    next_cyc();
    dp_spike = 1'b0;
    chk($sformatf("step%0d_spike_out", n), spike_out, v.sout);
    chk($sformatf("step%0d_done_req", n), dp_req, 0);
    next_cyc();
    chk($sformatf("step%0d_busy_after", n), busy, 0);
    chk($sformatf("step%0d_spike_out_after", n), spike_out, 0);
    chk($sformatf("step%0d_refrac_active", n), refrac_active, v.ract);
  endtask

  initial begin
    int t, t2, t3, t4, x;
    logic [1:0] op_first;
    step_vec_t quiet;

    // spk, op0, op1, sout, ract  (00 = UPDATE, 01 = CLAMP)
    tbl[0] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00};  // quiet step
    tbl[1] = '{2'b01, 2'b00, 2'b00, 2'b01, 2'b01};  // n0 spikes, refrac 2 loaded
    tbl[2] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b01};  // n0 clamped, spike ignored
    tbl[3] = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b00};  // n0 clamped, counter hits 0
    tbl[4] = '{2'b10, 2'b00, 2'b00, 2'b10, 2'b10};  // n0 updated again, n1 spikes
    tbl[5] = '{2'b11, 2'b00, 2'b01, 2'b01, 2'b11};  // n0 spikes, n1 clamped
    tbl[6] = '{2'b10, 2'b01, 2'b01, 2'b00, 2'b01};  // both clamped (refrac1 now 0)
    tbl[7] = '{2'b11, 2'b01, 2'b00, 2'b10, 2'b00};  // n1 spikes with period 0
    quiet  = tbl[0];

    // Reset state
    repeat (3) next_cyc();
    chk("rst_dp_req", dp_req, 0);
    chk("rst_step_tick", step_tick, 0);
    chk("rst_spike_out", spike_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_refrac_active", refrac_active, 0);

    rst = 1'b0;
    en = 1'b1;
    last_tick = cyc;

    // Table-driven steps: tick period, op sequencing, refractory behaviour
    for (int i = 0; i < 8; i++) begin
      if (i == 6) cfg_write(2'd2, 8'd0);  // refrac period n1 := 0
      run_step(tbl[i], i);
    end
    chk("overrun_clear_so_far", overrun, 0);

    // en=0 during REQ: step completes, no further ticks until en=1
    wait_tick(300, t);
    next_cyc();
    en = 1'b0;
    chk("en0_req0", dp_req, 1);
    next_cyc();
    chk("en0_req1", dp_req, 1);
    chk("en0_sel1", dp_sel, 1);
    next_cyc();
    chk("en0_done_busy", busy, 1);
    next_cyc();
    chk("en0_idle_busy", busy, 0);
    x = 0;
    for (int k = 0; k < 30; k++) begin
      next_cyc();
      if (step_tick) x++;
    end
    chk("en0_no_ticks", x, 0);
    en = 1'b1;
    x = cyc;
    wait_tick(300, t);
    chk("en1_resume_latency", t - x, 9);  // count held at 1

    // prescale=3 written while count=7: runs through 255 and wraps
    repeat (7) next_cyc();
    cfg_write(2'd0, 8'd3);
    wait_tick(300, t2);
    chk("wrap_first_tick", t2 - t, 260);
    wait_tick(300, t3);
    chk("wrap_period_a", t3 - t2, 4);
    wait_tick(300, t4);
    chk("wrap_period_b", t4 - t3, 4);
    cfg_write(2'd0, 8'd9);  // count is 0 here, no wrap

    // dp_ack held low 15 cycles: request stable, overrun, nothing queued
    wait_tick(300, t);
    chk("ack_low_tick_gap", t - t4, 10);
    dp_ack = 1'b0;
    op_first = 2'b00;
    for (int k = 1; k <= 15; k++) begin
      next_cyc();
      chk($sformatf("stall%0d_req", k), dp_req, 1);
      chk($sformatf("stall%0d_sel", k), dp_sel, 0);
      if (k == 1) op_first = dp_op;
      else chk($sformatf("stall%0d_op", k), dp_op, op_first);
    end
    chk("stall_overrun", overrun, 1);
    dp_ack = 1'b1;
    next_cyc();
    chk("stall_sel1", dp_sel, 1);
    next_cyc();
    chk("stall_done_req", dp_req, 0);
    chk("stall_done_busy", busy, 1);
    next_cyc();
    chk("stall_idle_busy", busy, 0);
    next_cyc();
    chk("stall_no_queue_req", dp_req, 0);
    chk("stall_no_queue_busy", busy, 0);
    next_cyc();
    chk("stall_next_tick", step_tick, 1);
    next_cyc();
    chk("stall_next_req", dp_req, 1);
    chk("overrun_sticky", overrun, 1);

    // Reset while REQ with idx=1 and a pending spike in the accumulator
    dp_spike = 1'b1;
    next_cyc();
    dp_spike = 1'b0;
    dp_ack = 1'b0;
    chk("mid_sel1", dp_sel, 1);
    chk("mid_refrac_active", refrac_active, 2'b01);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_dp_req", dp_req, 0);
    chk("arst_busy", busy, 0);
    chk("arst_overrun", overrun, 0);
    chk("arst_refrac_active", refrac_active, 0);
    chk("arst_spike_out", spike_out, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    dp_ack = 1'b1;
    last_tick = cyc;
    x = 0;
    for (int k = 0; k < 8; k++) begin
      next_cyc();
      if (spike_out != 2'b00 || dp_req) x++;
    end
    chk("post_rst_quiet", x, 0);
    run_step(quiet, 8);  // also confirms prescale back to 9

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
